// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared definitions for the uart_tx arbiter.
//   - arb_state_e      : arbiter FSM state encoding (3-bit, IDLE=0 .. HOLD=4)
//   - ARB_*_DEFAULT    : default requester count and mid-packet hold timeout
//   - REQ_HDR/PIX/DBG  : requester index assignment (0 has the highest fixed priority)
//   - onehot_idx()     : one-hot (up to 8 bits) to binary index
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } arb_state_e;

  localparam int ARB_N_DEFAULT            = 3;
  localparam int ARB_HOLD_TIMEOUT_DEFAULT = 1024;

  localparam int REQ_HDR = 0;  // frame-header generator
  localparam int REQ_PIX = 1;  // image pixel stream
  localparam int REQ_DBG = 2;  // debug/status text

  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_arb_pick.sv
// arb_pick: combinational winner selection for the uart_tx arbiter.
// Searches req starting at ptr (rr_en=1, wrapping modulo N) or at index 0
// (rr_en=0, fixed priority) and returns the first requester found, one-hot.
// Ports:
//   req   [N-1:0]  in   request vector
//   ptr   [PW-1:0] in   round-robin start index (ignored when rr_en=0)
//   rr_en          in   1 = rotating search, 0 = lowest index wins
//   win   [N-1:0]  out  one-hot winner, all zero when req is zero
module arb_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          rr_en,
  output logic [N-1:0]  win
);

  int            pos;
  logic [PW-1:0] idx;
  logic          found;

  // NOTE: every signal written here gets a default before the search, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      pos = (rr_en ? int'(ptr) : 0) + i;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between N byte-stream
// requesters. The grant is held for a whole packet (until req_last), and the
// uart_tx start/ready handshake is sequenced for every byte.
// Build option: define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// undefined gives fixed priority (lowest index wins) with no pointer logic.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid [N]    requester i presents a byte
//   req_data  [8N]   byte of requester i at [8i+7:8i]
//   req_last  [N]    byte is the last of requester i's packet
//   req_ack   [N]    one-cycle pulse, byte of requester i taken
//   grant     [N]    one-hot packet owner
//   busy             a packet is in progress
//   tx_data, tx_start  to uart_tx
//   tx_ready         from uart_tx, 1 = idle
//   revoked          one-cycle pulse when a grant is dropped by timeout
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N            = ARB_N_DEFAULT,
  parameter int HOLD_TIMEOUT = ARB_HOLD_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  input  logic           tx_ready,
  output logic           revoked
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_TIMEOUT - 1);

  arb_state_e    state, state_n;
  logic [N-1:0]  grant_n, req_ack_n, pick_win;
  logic [7:0]    tx_data_n, g_byte;
  logic          tx_start_n, revoked_n, last_r, last_n;
  logic          g_valid, g_last, advance;
  logic [CW-1:0] hold_cnt, hold_cnt_n;
  logic [PW-1:0] pick_ptr;
  logic          rr_en;

  // Granted requester's signals; grant is one-hot so OR-reduction is a mux.
  always_comb begin
    g_valid = |(req_valid & grant);
    g_last  = |(req_last & grant);
    g_byte  = '0;
    for (int i = 0; i < N; i++) begin
      g_byte = g_byte | (req_data[8*i +: 8] & {8{grant[i]}});
    end
  end

`ifdef UART_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr, rr_ptr_n, g_idx, g_next;

  assign rr_en    = 1'b1;
  assign pick_ptr = rr_ptr;
  assign g_idx    = PW'(onehot_idx(8'(grant)));
  assign g_next   = (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;

  // Pointer moves past the owner whenever a packet ends or is revoked.
  always_comb begin
    rr_ptr_n = rr_ptr;
    if (advance) rr_ptr_n = g_next;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= rr_ptr_n;
  end
`else
  assign rr_en    = 1'b0;
  assign pick_ptr = '0;
`endif

  arb_pick #(.N(N), .PW(PW)) u_pick (
    .req   (req_valid),
    .ptr   (pick_ptr),
    .rr_en (rr_en),
    .win   (pick_win)
  );

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    req_ack_n  = '0;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    revoked_n  = 1'b0;
    last_n     = last_r;
    hold_cnt_n = hold_cnt;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_n = pick_win;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (tx_ready && g_valid) begin
          tx_data_n  = g_byte;
          tx_start_n = 1'b1;
          req_ack_n  = grant;
          last_n     = g_last;
          state_n    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // uart_tx has not yet accepted the start until ready drops.
        if (!tx_ready) state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          if (last_r) begin
            grant_n = '0;
            advance = 1'b1;
            state_n = ST_IDLE;
          end else begin
            hold_cnt_n = '0;
            state_n    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Timeout wins over a byte arriving in the same cycle; that
        // requester re-arbitrates from IDLE instead.
        if (hold_cnt == CNT_MAX) begin
          grant_n    = '0;
          revoked_n  = 1'b1;
          advance    = 1'b1;
          hold_cnt_n = '0;
          state_n    = ST_IDLE;
        end else if (g_valid) begin
          hold_cnt_n = '0;
          state_n    = ST_LOAD;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous); state registers
  // use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      revoked  <= 1'b0;
      last_r   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      busy     <= |grant_n;
      req_ack  <= req_ack_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      revoked  <= revoked_n;
      last_r   <= last_n;
      hold_cnt <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter (N=3,
// HOLD_TIMEOUT=16). Behavioural requesters drain per-index byte queues,
// a uart_tx model holds ready low for 10 cycles per start, and a scoreboard
// of expected {requester, byte} pairs is compared on every tx_start.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int HT = 16;

  logic           clk, rst;
  logic [N-1:0]   req_valid, req_last, req_ack, grant;
  logic [8*N-1:0] req_data;
  logic           busy, tx_start, tx_ready, revoked;
  logic [7:0]     tx_data;
  logic           ready_m, block;

  assign tx_ready = ready_m & ~block;

  uart_tx_arbiter #(.N(N), .HOLD_TIMEOUT(HT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .grant     (grant),
    .busy      (busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .revoked   (revoked)
  );

  typedef struct packed {logic [7:0] b; logic last;} byte_t;
  typedef struct packed {logic [1:0] idx; logic [7:0] b;} exp_t;
  typedef struct {int idx; int len; logic [7:0] base; logic [N-1:0] exp_grant;} vec_t;

  byte_t rq [N][$];
  exp_t  sb [$];
  int    n_vec = 0, n_err = 0, cyc = 0, n_start = 0, rise_cyc = 0, mcnt = 0;
  int    ack_cnt [N];
  logic  prev_start = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // uart_tx model: updated on the falling edge so the arbiter sees ready
  // drop one cycle after start and stay low for 10 sampled cycles.
  initial begin
    ready_m = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_m = 1'b1;
        mcnt    = 0;
      end else if (tx_start) begin
        mcnt = 11;
      end else if (mcnt > 0) begin
        mcnt--;
        ready_m = (mcnt == 0);
        if (mcnt == 0) rise_cyc = cyc;
      end
    end
  end

  // Requesters: present the queue head, pop it on req_ack.
  initial begin
    req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_last[i]         = rq[i][0].last;
          req_data[8*i +: 8]  = rq[i][0].b;
        end else begin
          req_valid[i]        = 1'b0;
          req_last[i]         = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_start) begin
          n_start++;
          check("start_pulse_width", prev_start, 1'b0);
          check("sb_nonempty", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("tx_data", tx_data, e.b);
            check("req_ack_onehot", req_ack, 32'(1) << e.idx);
            check("grant_owner", grant, 32'(1) << e.idx);
          end
        end else if (req_ack != '0) begin
          check("ack_without_start", req_ack, 0);
        end
        for (int i = 0; i < N; i++) if (req_ack[i]) ack_cnt[i]++;
      end
      prev_start = tx_start;
    end
  end

  task automatic req_pkt(input int idx, input logic [7:0] base, input int len, input logic last_en);
    for (int k = 0; k < len; k++)
      rq[idx].push_back('{b: base + 8'(k), last: last_en && (k == len - 1)});
  endtask

  task automatic sb_pkt(input int idx, input logic [7:0] base, input int len);
    for (int k = 0; k < len; k++) sb.push_back('{idx: 2'(idx), b: base + 8'(k)});
  endtask

  task automatic wait_idle(input int budget);
    logic done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk); #1;
      done = !busy && sb.size() == 0 && rq[0].size() == 0 &&
             rq[1].size() == 0 && rq[2].size() == 0;
    end
    check("wait_idle_in_budget", done, 1'b1);
  endtask

  task automatic wait_grant(input int budget);
    logic done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk); #1;
      done = (grant != '0);
    end
    check("wait_grant_in_budget", done, 1'b1);
  endtask

  task automatic wait_revoked(input int budget);
    logic done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk); #1;
      done = revoked;
    end
    check("wait_revoked_in_budget", done, 1'b1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    logic done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk); #1;
      done = (n_start >= target);
    end
    check("wait_start_in_budget", done, 1'b1);
  endtask

  task automatic wait_acks(input int idx, input int target, input int budget);
    logic done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk); #1;
      done = (ack_cnt[idx] >= target);
    end
    check("wait_ack_in_budget", done, 1'b1);
  endtask

  initial begin
    vec_t vecs [4];
    int   a0, s0, c_rev;

    vecs[0] = '{idx: REQ_HDR, len: 3, base: 8'h10, exp_grant: 3'b001};
    vecs[1] = '{idx: REQ_DBG, len: 1, base: 8'h20, exp_grant: 3'b100};
    vecs[2] = '{idx: REQ_PIX, len: 4, base: 8'h30, exp_grant: 3'b010};
    vecs[3] = '{idx: REQ_DBG, len: 2, base: 8'hA0, exp_grant: 3'b100};

    block = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_revoked", revoked, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single packet from the pixel stream with first-byte latency.
    @(posedge clk); #1;
    a0 = ack_cnt[REQ_PIX];
    req_pkt(REQ_PIX, 8'h41, 2, 1'b1);
    sb_pkt(REQ_PIX, 8'h41, 2);
    @(negedge clk); #1;
    check("t1_valid_seen", req_valid[REQ_PIX], 1'b1);
    check("t1_grant_t0", grant, 3'b000);
    @(negedge clk); #1;
    check("t1_grant_t1", grant, 3'b010);
    check("t1_busy_t1", busy, 1'b1);
    check("t1_start_t1", tx_start, 1'b0);
    @(negedge clk); #1;
    check("t1_start_t2", tx_start, 1'b1);
    check("t1_ack_t2", req_ack, 3'b010);
    check("t1_data_t2", tx_data, 8'h41);
    wait_idle(200);
    check("t1_grant_after", grant, 3'b000);
    check("t1_ack_count", ack_cnt[REQ_PIX] - a0, 2);

    // Table of single-requester packets.
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      req_pkt(vecs[v].idx, vecs[v].base, vecs[v].len, 1'b1);
      sb_pkt(vecs[v].idx, vecs[v].base, vecs[v].len);
      wait_grant(50);
      check("tbl_grant", grant, vecs[v].exp_grant);
      wait_idle(400);
      check("tbl_busy_after", busy, 1'b0);
      check("tbl_grant_after", grant, 3'b000);
    end

    // Contention: header (two packets back to back) against debug.
    @(posedge clk); #1;
    req_pkt(REQ_HDR, 8'h50, 2, 1'b1);
    req_pkt(REQ_HDR, 8'h52, 1, 1'b1);
    req_pkt(REQ_DBG, 8'h60, 1, 1'b1);
    sb_pkt(REQ_HDR, 8'h50, 2);
`ifdef UART_ARB_ROUND_ROBIN_EN
    sb_pkt(REQ_DBG, 8'h60, 1);
    sb_pkt(REQ_HDR, 8'h52, 1);
`else
    sb_pkt(REQ_HDR, 8'h52, 1);
    sb_pkt(REQ_DBG, 8'h60, 1);
`endif
    wait_grant(50);
    check("t2_first_grant", grant, 3'b001);
    wait_idle(600);

    // Packet atomicity: pixel request arrives mid-way through a header.
    @(posedge clk); #1;
    a0 = ack_cnt[REQ_HDR];
    req_pkt(REQ_HDR, 8'hC0, 12, 1'b1);
    sb_pkt(REQ_HDR, 8'hC0, 12);
    wait_acks(REQ_HDR, a0 + 3, 200);
    req_pkt(REQ_PIX, 8'hD0, 2, 1'b1);
    sb_pkt(REQ_PIX, 8'hD0, 2);
    wait_idle(1000);

    // Timeout: debug sends a non-last byte then goes quiet.
    @(posedge clk); #1;
    req_pkt(REQ_DBG, 8'h70, 1, 1'b0);
    sb_pkt(REQ_DBG, 8'h70, 1);
    wait_grant(50);
    check("t4_grant", grant, 3'b100);
    req_pkt(REQ_PIX, 8'hB0, 2, 1'b1);
    sb_pkt(REQ_PIX, 8'hB0, 2);
    wait_revoked(200);
    c_rev = cyc;
    check("t4_revoke_latency", c_rev - rise_cyc, 17);
    check("t4_grant_at_revoke", grant, 3'b000);
    @(negedge clk); #1;
    check("t4_revoked_one_cycle", revoked, 1'b0);
    check("t4_next_grant", grant, 3'b010);
    wait_idle(400);

    // Reset while uart_tx is mid-byte.
    @(posedge clk); #1;
    s0 = n_start;
    req_pkt(REQ_PIX, 8'h90, 2, 1'b1);
    sb_pkt(REQ_PIX, 8'h90, 2);
    wait_starts(s0 + 1, 50);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("t5_grant", grant, 0);
    check("t5_busy", busy, 0);
    check("t5_req_ack", req_ack, 0);
    check("t5_tx_start", tx_start, 0);
    check("t5_tx_data", tx_data, 8'h00);
    check("t5_revoked", revoked, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("t5_fresh_grant", grant, 3'b010);
    @(negedge clk); #1;
    check("t5_restart", tx_start, 1'b1);
    check("t5_restart_data", tx_data, 8'h91);
    wait_idle(200);

    // uart_tx busy at grant time: start withheld until ready.
    @(posedge clk); #1;
    block = 1'b1;
    s0 = n_start;
    req_pkt(REQ_HDR, 8'h80, 1, 1'b1);
    sb_pkt(REQ_HDR, 8'h80, 1);
    repeat (8) @(negedge clk);
    #1;
    check("t6_grant_while_blocked", grant, 3'b001);
    check("t6_no_start_while_blocked", n_start - s0, 0);
    block = 1'b0;
    wait_idle(200);
    check("t6_single_start", n_start - s0, 1);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
